mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one N:1 mux datapath between N_REQ requesters.
//  - Each requester presents a valid/ready/data channel.
//  - The arbiter picks one requester per transfer and drives the shared mux select.
//  - The selected word is registered into a single output stage with valid/ready.
//  - Sits in front of any shared consumer of mux-steered data (gate/LUT units, output channel).

---
 rtl/mux_rr_arbiter.sv | 99 +++++++++
 tb/tb_mux_rr_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering N_REQ valid/ready channels through one shared mux into a registered output stage.
// Latency 1 cycle from accept to out_valid; 1 word/cycle sustained. Backpressure: out_ready low holds the stage and drops every in_ready.
// Optional MUX_RR_ARBITER_LOCK_EN adds in_lock so a locked requester keeps priority while it stays valid.
module mux_rr_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       in_valid,
    output logic [N_REQ-1:0]       in_ready,
    input  logic [N_REQ*WIDTH-1:0] in_data,
`ifdef MUX_RR_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]       in_lock,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_id
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic             load_ok;
    logic             gnt_vld;
    logic             xfer;
    logic [ID_W-1:0]  sel;

    assign load_ok = !out_valid_q || out_ready;

    // Scan from the far end back towards ptr so the nearest valid index wins.
    always_comb begin
        int j;
        j       = 0;
        sel     = '0;
        gnt_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (in_valid[j]) begin
                sel     = ID_W'(j);
                gnt_vld = 1'b1;
            end
        end
    end

    // rst_n gating keeps in_ready low while the output stage is held in reset.
    assign xfer = load_ok && gnt_vld && rst_n;

    always_comb begin
        in_ready      = '0;
        in_ready[sel] = xfer;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(sel)*WIDTH +: WIDTH];
            out_id_d    = sel;
            ptr_d       = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
`ifdef MUX_RR_ARBITER_LOCK_EN
            if (in_lock[sel]) begin
                ptr_d = sel;
            end
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (N_REQ=4, WIDTH=8) with hand-computed expectations.
module tb_mux_rr_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       in_valid;
    logic [N_REQ-1:0]       in_ready;
    logic [N_REQ*WIDTH-1:0] in_data;
    logic [N_REQ-1:0]       in_lock;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [1:0]             out_id;

    int n_checks;
    int n_errors;

    mux_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef MUX_RR_ARBITER_LOCK_EN
        .in_lock   (in_lock),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester i carries 16*c + i in cycle c, so data identifies both source and cycle.
    task automatic set_data(input int c);
        for (int i = 0; i < N_REQ; i++) begin
            in_data[i*WIDTH +: WIDTH] = 8'(16*c + i);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_lock   = '0;
        out_ready = 1'b0;
        in_data   = '0;

        // Power-on reset
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_id",    32'(out_id),    32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;
        tick();

        // Single requester 2
        in_data               = '0;
        in_data[2*WIDTH +: 8] = 8'hA5;
        in_valid              = 4'b0100;
        out_ready             = 1'b1;
        #1;
        check("single_in_ready", 32'(in_ready), 32'b0100);
        tick();
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_data",  32'(out_data),  32'hA5);
        check("single_out_id",    32'(out_id),    32'd2);

        // Stall, then asynchronous reset mid-cycle
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data",  32'(out_data),  32'd0);
        check("arst_out_id",    32'(out_id),    32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd0);
        tick();
        rst_n = 1'b1;

        // All valid, streaming: ptr restarts at 0 after reset
        for (int c = 0; c < 8; c++) begin
            set_data(c);
            in_valid  = 4'b1111;
            out_ready = 1'b1;
            #1;
            check("rr_in_ready", 32'(in_ready), 32'(1 << (c % 4)));
            tick();
            check("rr_out_valid", 32'(out_valid), 32'd1);
            check("rr_out_id",    32'(out_id),    32'(c % 4));
            check("rr_out_data",  32'(out_data),  32'(16*c + c % 4));
        end

        // Backpressure for 3 cycles: last word (id 3, 8'h73) frozen
        for (int c = 0; c < 3; c++) begin
            set_data(8);
            out_ready = 1'b0;
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_id",    32'(out_id),    32'd3);
            check("bp_out_data",  32'(out_data),  32'h73);
        end
        set_data(9);
        out_ready = 1'b1;
        #1;
        check("bp_rel_in_ready", 32'(in_ready), 32'b0001);
        tick();
        check("bp_rel_out_id",   32'(out_id),   32'd0);
        check("bp_rel_out_data", 32'(out_data), 32'h90);

        // Sparse requesters 0 and 3 with ptr at 1
        set_data(10);
        in_valid = 4'b1001;
        #1;
        check("sparse_in_ready_a", 32'(in_ready), 32'b1000);
        tick();
        check("sparse_out_id_a",   32'(out_id),   32'd3);
        check("sparse_out_data_a", 32'(out_data), 32'hA3);
        set_data(11);
        #1;
        check("sparse_in_ready_b", 32'(in_ready), 32'b0001);
        tick();
        check("sparse_out_id_b",   32'(out_id),   32'd0);
        check("sparse_out_data_b", 32'(out_data), 32'hB0);

        // Nothing valid while draining: stage empties
        in_valid = 4'b0000;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);

`ifdef MUX_RR_ARBITER_LOCK_EN
        // ptr is 1: locked requester 1 keeps the grant until it drops valid
        in_lock  = 4'b0010;
        in_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            set_data(12 + c);
            tick();
            check("lock_out_id",   32'(out_id),   32'd1);
            check("lock_out_data", 32'(out_data), 32'(16*(12 + c) + 1));
        end
        in_valid = 4'b1101;
        tick();
        check("lock_rel_out_id", 32'(out_id), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
